noc_packet_injector: RTL

Clocked packet source at the root port of the NOC tree. It replaces the ad-hoc data generators used in bench bring-up. A run first sends one filter packet to each processing element (PE), then streams a programmed number of input packets to the PEs in round-robin order. Packets are formatted and queued in a small FIFO. The FIFO drives the tree root over a valid/ready link.

---
 rtl/noc_packet_injector.sv | 86 ++++++++
 1 files changed

// File: rtl/noc_packet_injector.sv
// noc_packet_injector: filter-then-input packet source feeding the NOC tree root through a small FIFO
module noc_packet_injector #(
  parameter int NUM_PE = 3,
  parameter int DEPTH = 4,
  parameter int PAYLOAD_W = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_inputs,
  input  logic                 filt_valid,
  output logic                 filt_ready,
  input  logic [PAYLOAD_W-1:0] filt_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [31:0]          pkt_data,
  output logic                 busy,
  output logic                 done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, FILTER = 2'd1, INPUT = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [2:0] pe_cnt, pe_next;
  logic [7:0] in_cnt, nin;
  logic full, empty, push, pop, pe_last;
  logic [23:0] payload;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign filt_ready = state == FILTER && !full;
  assign in_ready = state == INPUT && !full;
  assign push = (filt_valid && filt_ready) || (in_valid && in_ready);
  assign pop = pkt_valid && pkt_ready;
  assign pkt_valid = !empty;
  assign pkt_data = empty ? '0 : mem[rd_ptr];
  assign busy = state != IDLE;
  assign payload = state == FILTER ? 24'(filt_data) : 24'(in_data);
  assign pe_last = pe_cnt == 3'(NUM_PE);
  assign pe_next = pe_last ? 3'd1 : pe_cnt + 3'd1;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {1'b0, state == FILTER, pe_cnt, 3'b000, payload};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pe_cnt <= '0;
      in_cnt <= '0;
      nin <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (state == IDLE) begin
        if (start) begin
          state <= FILTER;
          nin <= num_inputs;
          pe_cnt <= 3'd1;
          in_cnt <= '0;
        end
      end else if (state == FILTER) begin
        if (push) begin
          pe_cnt <= pe_next;
          if (pe_last) state <= nin != '0 ? INPUT : DRAIN;
        end
      end else if (state == INPUT) begin
        if (push) begin
          pe_cnt <= pe_next;
          in_cnt <= in_cnt + 8'd1;
          if (in_cnt + 8'd1 == nin) state <= DRAIN;
        end
      end else if (empty) begin
        done <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule
